// File: rtl/adpll_pkg.sv
// Shared ADPLL constants, types and the FCW clamp helper used by the DCO and the loop filter.
package adpll_pkg;

  localparam int ACC_W_DEF      = 16;
  localparam int CTRL_W_DEF     = 12;
  localparam int FCW_CENTER_DEF = 4096;
  localparam int FCW_MIN_DEF    = 1024;
  localparam int FCW_MAX_DEF    = 16384;

  typedef logic [ACC_W_DEF-1:0] fcw_t;

  // Update-path state: IDLE can accept a new FCW, PEND holds one until the next wrap.
  typedef enum logic {
    UPD_IDLE = 1'b0,
    UPD_PEND = 1'b1
  } upd_state_e;

  function automatic int fcw_clamp(input int v, input int lo, input int hi);
    int r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/fcw_sat.sv
// Offset-add of the signed loop-filter word onto the centre increment, then clamp to the legal range.
module fcw_sat
  import adpll_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int CTRL_W     = CTRL_W_DEF,
  parameter int FCW_CENTER = FCW_CENTER_DEF,
  parameter int FCW_MIN    = FCW_MIN_DEF,
  parameter int FCW_MAX    = FCW_MAX_DEF
) (
  input  logic [CTRL_W-1:0] fcw_in,
  output logic [ACC_W-1:0]  eff,
  output logic              sat
);

  localparam int SW = ACC_W + 2;
  localparam logic [ACC_W-1:0] CENTER_W = ACC_W'(FCW_CENTER);

  logic signed [SW-1:0] sum_s;
  int                   sum_i;
  int                   clamp_i;

  // Two guard bits keep centre + most-negative/most-positive offset from overflowing.
  always_comb begin
    sum_s   = signed'({2'b00, CENTER_W})
            + signed'({{(SW-CTRL_W){fcw_in[CTRL_W-1]}}, fcw_in});
    sum_i   = int'(sum_s);
    clamp_i = fcw_clamp(sum_i, FCW_MIN, FCW_MAX);
    sat     = (clamp_i != sum_i);
    eff     = clamp_i[ACC_W-1:0];
  end

endmodule

// File: rtl/dco_nco.sv
// Phase-accumulator DCO: dco_out is the accumulator MSB; FCW updates are handshaked and
// only take effect at a wrap so a period is never cut short.
//
// Handshake: an FCW is accepted on a clk edge where fcw_valid && fcw_ready; fcw_ready is a
// pure function of registered state (no path from fcw_valid), and stays low from the edge
// after acceptance until the edge at which the pending value is applied at a wrap.
module dco_nco
  import adpll_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int CTRL_W     = CTRL_W_DEF,
  parameter int FCW_CENTER = FCW_CENTER_DEF,
  parameter int FCW_MIN    = FCW_MIN_DEF,
  parameter int FCW_MAX    = FCW_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CTRL_W-1:0] fcw_in,
  input  logic              fcw_valid,
  output logic              fcw_ready,
  output logic              dco_out,
  output logic              dco_tick,
  output logic [ACC_W-1:0]  fcw_active,
  output logic              sat_flag,
  output upd_state_e        upd_state
);

  localparam logic [ACC_W-1:0] CENTER_W = ACC_W'(FCW_CENTER);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] fcw_active_q, fcw_active_d;
  logic [ACC_W-1:0] pend_q, pend_d;
  logic             dco_q, dco_d;
  logic             tick_q, tick_d;
  logic             sat_q, sat_d;
  upd_state_e       state_q, state_d;

  logic [ACC_W:0]   sum;
  logic             wrap;
  logic [ACC_W-1:0] eff;
  logic             sat_w;

  fcw_sat #(
    .ACC_W      (ACC_W),
    .CTRL_W     (CTRL_W),
    .FCW_CENTER (FCW_CENTER),
    .FCW_MIN    (FCW_MIN),
    .FCW_MAX    (FCW_MAX)
  ) u_fcw_sat (
    .fcw_in (fcw_in),
    .eff    (eff),
    .sat    (sat_w)
  );

  // Accumulator: carry out of the ACC_W+1 bit sum marks the wrap.
  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, fcw_active_q};
    wrap   = en & sum[ACC_W];
    acc_d  = acc_q;
    dco_d  = dco_q;
    tick_d = wrap;
    if (en) begin
      acc_d = sum[ACC_W-1:0];
      dco_d = sum[ACC_W-1];
    end
  end

  // Update path. An accept in IDLE on a wrap cycle only captures; apply waits for the next wrap.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    sat_d        = sat_q;
    fcw_active_d = fcw_active_q;
    case (state_q)
      UPD_IDLE: begin
        if (fcw_valid) begin
          pend_d  = eff;
          sat_d   = sat_w;
          state_d = UPD_PEND;
        end
      end
      UPD_PEND: begin
        if (wrap) begin
          fcw_active_d = pend_q;
          state_d      = UPD_IDLE;
        end
      end
      default: state_d = UPD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      fcw_active_q <= CENTER_W;
      pend_q       <= '0;
      dco_q        <= 1'b0;
      tick_q       <= 1'b0;
      sat_q        <= 1'b0;
      state_q      <= UPD_IDLE;
    end else begin
      acc_q        <= acc_d;
      fcw_active_q <= fcw_active_d;
      pend_q       <= pend_d;
      dco_q        <= dco_d;
      tick_q       <= tick_d;
      sat_q        <= sat_d;
      state_q      <= state_d;
    end
  end

  assign fcw_ready  = (state_q == UPD_IDLE);
  assign dco_out    = dco_q;
  assign dco_tick   = tick_q;
  assign fcw_active = fcw_active_q;
  assign sat_flag   = sat_q;
  assign upd_state  = state_q;

endmodule

// File: tb/tb_dco_nco.sv
// Directed bench for dco_nco with ACC_W=8, CENTER=32, MIN=8, MAX=64; offset is 7 bits wide so +32 is representable.
module tb_dco_nco;
  import adpll_pkg::*;

  localparam int ACC_W  = 8;
  localparam int CTRL_W = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [CTRL_W-1:0] fcw_in = '0;
  logic              fcw_valid = 1'b0;
  logic              fcw_ready;
  logic              dco_out;
  logic              dco_tick;
  logic [ACC_W-1:0]  fcw_active;
  logic              sat_flag;
  upd_state_e        upd_state;

  int checks = 0;
  int failures = 0;

  dco_nco #(
    .ACC_W      (ACC_W),
    .CTRL_W     (CTRL_W),
    .FCW_CENTER (32),
    .FCW_MIN    (8),
    .FCW_MAX    (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fcw_in     (fcw_in),
    .fcw_valid  (fcw_valid),
    .fcw_ready  (fcw_ready),
    .dco_out    (dco_out),
    .dco_tick   (dco_tick),
    .fcw_active (fcw_active),
    .sat_flag   (sat_flag),
    .upd_state  (upd_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive and sample on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic send(input int v);
    fcw_in    = CTRL_W'(v);
    fcw_valid = 1'b1;
    cyc();
    fcw_valid = 1'b0;
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!dco_tick && n < limit);
    if (!dco_tick) check("tick_timeout", 32'(n), 32'(limit + 1));
  endtask

  task automatic measure(input string tag, input int exp_per, input int exp_high);
    int per;
    int high;
    per = 0;
    high = 0;
    do begin
      cyc();
      per++;
      high += int'(dco_out);
    end while (!dco_tick && per < 200);
    check({tag, "_period"}, 32'(per), 32'(exp_per));
    check({tag, "_high"}, 32'(high), 32'(exp_high));
  endtask

  initial begin
    int n;
    bit ready_stayed_low;

    // Reset state
    cyc();
    check("rst_dco", 32'(dco_out), 0);
    check("rst_tick", 32'(dco_tick), 0);
    check("rst_active", 32'(fcw_active), 32);
    check("rst_ready", 32'(fcw_ready), 1);
    check("rst_sat", 32'(sat_flag), 0);
    check("rst_state", 32'(upd_state), 32'(UPD_IDLE));

    // Free run at centre: first wrap on the 8th edge, period 8, 4 high
    rst = 1'b0;
    en  = 1'b1;
    wait_tick(50, n);
    check("first_tick", 32'(n), 8);
    measure("center", 8, 4);
    check("center_active", 32'(fcw_active), 32);

    // +32 mid-period: ready drops until the wrap, then period 4
    repeat (3) cyc();
    send(32);
    check("up_ready_low", 32'(fcw_ready), 0);
    check("up_state", 32'(upd_state), 32'(UPD_PEND));
    check("up_not_applied", 32'(fcw_active), 32);
    ready_stayed_low = 1'b1;
    n = 0;
    while (!dco_tick && n < 50) begin
      if (fcw_ready) ready_stayed_low = 1'b0;
      cyc();
      n++;
    end
    check("up_ready_held", 32'(ready_stayed_low), 1);
    check("up_ready_back", 32'(fcw_ready), 1);
    check("up_active", 32'(fcw_active), 64);
    check("up_sat", 32'(sat_flag), 0);
    measure("up", 4, 2);

    // -31 clamps eff 1 up to 8
    cyc();
    send(-31);
    check("lo_sat", 32'(sat_flag), 1);
    wait_tick(100, n);
    check("lo_active", 32'(fcw_active), 8);
    measure("lo", 32, 16);

    // 0 returns to centre and clears sat
    send(0);
    check("zero_sat", 32'(sat_flag), 0);
    wait_tick(100, n);
    check("zero_active", 32'(fcw_active), 32);
    measure("zero", 8, 4);

    // Valid on the exact wrap cycle: captured only, one more old period
    repeat (7) cyc();
    fcw_in    = CTRL_W'(-16);
    fcw_valid = 1'b1;
    cyc();
    fcw_valid = 1'b0;
    check("wrapacc_tick", 32'(dco_tick), 1);
    check("wrapacc_ready", 32'(fcw_ready), 0);
    check("wrapacc_active", 32'(fcw_active), 32);
    measure("wrapacc_old", 8, 4);
    check("wrapacc_applied", 32'(fcw_active), 16);
    measure("wrapacc_new", 16, 8);

    // en low for 5 edges during the high phase; handshake still accepts
    repeat (10) cyc();
    check("hold_pre_dco", 32'(dco_out), 1);
    en = 1'b0;
    send(-16);
    check("hold_ready", 32'(fcw_ready), 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("hold_dco", 32'(dco_out), 1);
      check("hold_tick", 32'(dco_tick), 0);
    end
    check("hold_active", 32'(fcw_active), 16);
    en = 1'b1;
    wait_tick(50, n);
    check("hold_resume", 32'(n), 6);
    check("hold_ready_back", 32'(fcw_ready), 1);
    measure("hold_after", 16, 8);

    // Exact lower bound is not a clamp; large positive offset clamps to 64
    send(-24);
    check("min_exact_sat", 32'(sat_flag), 0);
    wait_tick(100, n);
    check("min_exact_active", 32'(fcw_active), 8);
    send(63);
    check("max_sat", 32'(sat_flag), 1);
    wait_tick(100, n);
    check("max_active", 32'(fcw_active), 64);
    measure("max", 4, 2);

    // Reset with an update pending: immediate reset values, pending discarded
    send(-24);
    check("prerst_ready", 32'(fcw_ready), 0);
    cyc();
    rst = 1'b1;
    #1;
    check("arst_dco", 32'(dco_out), 0);
    check("arst_active", 32'(fcw_active), 32);
    check("arst_ready", 32'(fcw_ready), 1);
    check("arst_sat", 32'(sat_flag), 0);
    check("arst_tick", 32'(dco_tick), 0);
    cyc();
    rst = 1'b0;
    wait_tick(50, n);
    check("postrst_first", 32'(n), 8);
    check("postrst_active", 32'(fcw_active), 32);
    measure("postrst", 8, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
